// File: rtl/gesture_path_gen_if.sv
// Control and coordinate-stream bundle for gesture_path_gen.
// The master side (controller or bench) issues start/dir/loops/abort.
// The slave side (the generator) returns the x/y stream and status strobes.
interface gesture_path_gen_if;
  logic        start;
  logic        dir;
  logic [3:0]  loops;
  logic        abort;
  logic [15:0] x;
  logic [15:0] y;
  logic        valid;
  logic        busy;
  logic        done;

  modport master (
    output start, dir, loops, abort,
    input  x, y, valid, busy, done
  );

  modport slave (
    input  start, dir, loops, abort,
    output x, y, valid, busy, done
  );
endinterface

// File: rtl/gesture_path_gen.sv
// gesture_path_gen: self-test stimulus source that traces the 8-waypoint ring
// gesture as a registered x/y stream.
// The trace runs forward or reverse for a latched number of loops and ends on
// a closing point at waypoint 0.
// Every waypoint is held for DWELL cycles. valid marks the first cycle of each
// point, and done pulses once after a normal completion.
module gesture_path_gen #(
  parameter int LO    = 2,
  parameter int MID   = 5,
  parameter int HI    = 7,
  parameter int DWELL = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  gesture_path_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLOSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Last value of the per-point dwell counter before the point changes.
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q,   idx_d;
  logic [15:0] dwell_q, dwell_d;
  logic [3:0]  loop_q,  loop_d;
  logic        dir_q,   dir_d;
  logic [15:0] x_q,     x_d;
  logic [15:0] y_q,     y_d;
  logic        valid_q, valid_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic        dwell_end_s;
  logic [2:0]  idx_step_s;

  // Waypoint table, x column: 0:MID 1..3:LO 4:MID 5..7:HI.
  function automatic logic [15:0] wp_x(input logic [2:0] i);
    case (i)
      3'd0, 3'd4:       wp_x = 16'(MID);
      3'd1, 3'd2, 3'd3: wp_x = 16'(LO);
      3'd5, 3'd6, 3'd7: wp_x = 16'(HI);
      default:          wp_x = 16'd0;
    endcase
  endfunction

  // Waypoint table, y column: 0..1:HI 2:MID 3..5:LO 6:MID 7:HI.
  function automatic logic [15:0] wp_y(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd7: wp_y = 16'(HI);
      3'd2, 3'd6:       wp_y = 16'(MID);
      3'd3, 3'd4, 3'd5: wp_y = 16'(LO);
      default:          wp_y = 16'd0;
    endcase
  endfunction

  // The dwell expires on the last cycle of a point.
  // The ring index wraps mod 8 in the latched direction.
  assign dwell_end_s = (dwell_q == DWELL_LAST);
  assign idx_step_s  = dir_q ? (idx_q - 3'd1) : (idx_q + 3'd1);

  // Next-state and next-output logic. Outputs default to the idle pattern.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    dir_d   = dir_q;
    x_d     = 16'd0;
    y_d     = 16'd0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d   = 3'd0;
        dwell_d = 16'd0;
        loop_d  = 4'd0;
        if (bus.start) begin
          dir_d = bus.dir;
          if (bus.loops != 4'd0) begin
            state_d = ST_RUN;
            loop_d  = bus.loops;
            x_d     = wp_x(3'd0);
            y_d     = wp_y(3'd0);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            // An empty trace completes at once, with no points.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        busy_d = 1'b1;
        x_d    = wp_x(idx_q);
        y_d    = wp_y(idx_q);
        if (bus.abort) begin
          // Abort beats dwell expiry and leaves without a done pulse.
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          dwell_d = 16'd0;
          loop_d  = 4'd0;
          busy_d  = 1'b0;
          x_d     = 16'd0;
          y_d     = 16'd0;
        end else if (dwell_end_s) begin
          dwell_d = 16'd0;
          idx_d   = idx_step_s;
          valid_d = 1'b1;
          x_d     = wp_x(idx_step_s);
          y_d     = wp_y(idx_step_s);
          if (idx_step_s == 3'd0) begin
            // Back at waypoint 0 means one ring is complete.
            loop_d = loop_q - 4'd1;
            if (loop_q == 4'd1) begin
              state_d = ST_CLOSE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end

      ST_CLOSE: begin
        busy_d = 1'b1;
        x_d    = wp_x(3'd0);
        y_d    = wp_y(3'd0);
        if (bus.abort) begin
          state_d = ST_IDLE;
          dwell_d = 16'd0;
          busy_d  = 1'b0;
          x_d     = 16'd0;
          y_d     = 16'd0;
        end else if (dwell_end_s) begin
          state_d = ST_DONE;
          dwell_d = 16'd0;
          busy_d  = 1'b0;
          x_d     = 16'd0;
          y_d     = 16'd0;
          done_d  = 1'b1;
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at in the done cycle.
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        dwell_d = 16'd0;
        loop_d  = 4'd0;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        dwell_d = 16'd0;
        loop_d  = 4'd0;
        dir_d   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      dwell_q <= 16'd0;
      loop_q  <= 4'd0;
      dir_q   <= 1'b0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      loop_q  <= loop_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
